core_wb_bridge: RTL and testbench

Registered bridge between the core's level-held `memory_read`/`memory_write`/`memory_response` port and the Controller's Wishbone classic slave port (`core_cyc/stb/we/addr/data`, `core_ack`). It replaces the combinational `cyc = stb = read | write` glue in the top level. It also adds:
- one-request holding registers, so bus signals are glitch-free and stable for the whole cycle;
- a one-cycle response pulse with registered read data;
- a bus watchdog, so an unacknowledged access cannot hang the core.

---
 rtl/core_bus_pkg.sv | 16 +
 rtl/bus_watchdog.sv | 36 +++
 rtl/core_wb_bridge.sv | 143 ++++++++++++++
 tb/tb_core_wb_bridge.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_bus_pkg.sv
// Shared types and constants for the core-side Wishbone bridges.
package core_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  // Read data handed back to the core when the watchdog aborts a read.
  localparam logic [BUS_DATA_W-1:0] TIMEOUT_RDATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } bridge_state_t;

endpackage

// File: rtl/bus_watchdog.sv
// Saturating bus watchdog: counts enabled cycles since the last clear and
// flags the cycle in which the count reaches LIMIT. LIMIT = 0 disables it.
module bus_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT <= 0) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM    = CW'(LIMIT);
  localparam logic [CW-1:0] LIM_M1 = (LIMIT <= 0) ? '0 : CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry is the cycle whose increment would bring the count to LIMIT, so
  // the owner leaves its wait state after exactly LIMIT enabled cycles.
  assign expired = (LIMIT > 0) && enable && (cnt_q == LIM_M1);

  // Next count: clear wins, otherwise increment until saturated at LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)                       cnt_d = '0;
    else if (enable && cnt_q != LIM) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/core_wb_bridge.sv
// Registered bridge from the core's level-held read/write request port to a
// Wishbone classic master, with a one-cycle response pulse and a watchdog
// that aborts accesses the slave never acknowledges.
module core_wb_bridge
  import core_bus_pkg::*;
#(
  parameter int                ADDR_W         = BUS_ADDR_W,
  parameter int                DATA_W         = BUS_DATA_W,
  parameter int                TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = DATA_W'(TIMEOUT_RDATA_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_read_i,
  input  logic              core_write_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_response_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              wb_ack_i,
  input  logic              err_clr_i,
  output logic              timeout_o,
  output logic [ADDR_W-1:0] err_addr_o
);

  bridge_state_t state_q, state_d;

  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              resp_q, resp_d;
  logic              tout_q, tout_d;
  logic [ADDR_W-1:0] eaddr_q, eaddr_d;

  logic req, start, done_ack, abort, wd_expired;

  assign req      = core_read_i | core_write_i;
  assign start    = (state_q == IDLE) && req;
  assign done_ack = (state_q == BUS) && wb_ack_i;
  // Ack in the expiry cycle is a normal completion, never an abort.
  assign abort    = (state_q == BUS) && !wb_ack_i && wd_expired;

  bus_watchdog #(
    .LIMIT   (TIMEOUT_CYCLES)
  ) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start),
    .enable  ((state_q == BUS) && !wb_ack_i),
    .expired (wd_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: RESP is a single cooldown cycle where requests are ignored
  // because the core is still dropping the request it just got answered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = BUS;
      BUS:     if (wb_ack_i || wd_expired) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values: every bus and core output is taken from a flop.
  always_comb begin
    cyc_d   = (state_d == BUS);
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    resp_d  = done_ack | abort;
    tout_d  = tout_q;
    eaddr_d = eaddr_q;

    if (start) begin
      we_d    = core_write_i;      // write wins when both are raised
      addr_d  = core_addr_i;
      wdata_d = core_wdata_i;
    end

    if (done_ack && !we_q) rdata_d = wb_data_i;
    if (abort    && !we_q) rdata_d = TIMEOUT_RDATA;

    // Sticky error: an abort beats a simultaneous clear. After a clear the
    // aborting access counts as the first error again.
    if (abort) begin
      tout_d = 1'b1;
      if (!tout_q || err_clr_i) eaddr_d = addr_q;
    end else if (err_clr_i) begin
      tout_d  = 1'b0;
      eaddr_d = '0;
    end
  end

  // Holding, response and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      tout_q  <= 1'b0;
      eaddr_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      tout_q  <= tout_d;
      eaddr_q <= eaddr_d;
    end
  end

  assign wb_cyc_o        = cyc_q;
  assign wb_stb_o        = cyc_q;
  assign wb_we_o         = cyc_q & we_q;
  assign wb_addr_o       = addr_q;
  assign wb_data_o       = wdata_q;
  assign core_rdata_o    = rdata_q;
  assign core_response_o = resp_q;
  assign timeout_o       = tout_q;
  assign err_addr_o      = eaddr_q;

endmodule

// File: tb/tb_core_wb_bridge.sv
// Directed bench for core_wb_bridge with an 8-cycle watchdog.
module tb_core_wb_bridge;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_read_i, core_write_i;
  logic [AW-1:0] core_addr_i;
  logic [DW-1:0] core_wdata_i;
  logic [DW-1:0] core_rdata_o;
  logic          core_response_o;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_data_o;
  logic [DW-1:0] wb_data_i;
  logic          wb_ack_i;
  logic          err_clr_i;
  logic          timeout_o;
  logic [AW-1:0] err_addr_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  core_wb_bridge #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (8),
    .TIMEOUT_RDATA  (32'hDEAD_BEEF)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .core_read_i     (core_read_i),
    .core_write_i    (core_write_i),
    .core_addr_i     (core_addr_i),
    .core_wdata_i    (core_wdata_i),
    .core_rdata_o    (core_rdata_o),
    .core_response_o (core_response_o),
    .wb_cyc_o        (wb_cyc_o),
    .wb_stb_o        (wb_stb_o),
    .wb_we_o         (wb_we_o),
    .wb_addr_o       (wb_addr_o),
    .wb_data_o       (wb_data_o),
    .wb_data_i       (wb_data_i),
    .wb_ack_i        (wb_ack_i),
    .err_clr_i       (err_clr_i),
    .timeout_o       (timeout_o),
    .err_addr_o      (err_addr_o)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_read_i  = 1'b0;
    core_write_i = 1'b0;
    wb_ack_i     = 1'b0;
    err_clr_i    = 1'b0;
  endtask

  int n, pulses, cycs;

  initial begin
    rst_n        = 1'b0;
    core_addr_i  = '0;
    core_wdata_i = '0;
    wb_data_i    = '0;
    idle_inputs();
    #3;
    chk("rst_cyc",   {63'd0, wb_cyc_o}, 64'd0);
    chk("rst_stb",   {63'd0, wb_stb_o}, 64'd0);
    chk("rst_resp",  {63'd0, core_response_o}, 64'd0);
    chk("rst_rdata", {32'd0, core_rdata_o}, 64'd0);
    chk("rst_tout",  {63'd0, timeout_o}, 64'd0);
    chk("rst_eaddr", {32'd0, err_addr_o}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Zero-wait read
    core_read_i = 1'b1; core_addr_i = 32'h100;
    tick();
    chk("zw_cyc",  {63'd0, wb_cyc_o}, 64'd1);
    chk("zw_stb",  {63'd0, wb_stb_o}, 64'd1);
    chk("zw_we",   {63'd0, wb_we_o}, 64'd0);
    chk("zw_addr", {32'd0, wb_addr_o}, 64'h100);
    chk("zw_resp_early", {63'd0, core_response_o}, 64'd0);
    wb_ack_i = 1'b1; wb_data_i = 32'h1234_5678;
    tick();
    chk("zw_resp",  {63'd0, core_response_o}, 64'd1);
    chk("zw_rdata", {32'd0, core_rdata_o}, 64'h1234_5678);
    chk("zw_cyc_off", {63'd0, wb_cyc_o}, 64'd0);
    idle_inputs();
    tick();
    chk("zw_resp_one", {63'd0, core_response_o}, 64'd0);
    tick();

    // Wait-state write, ack in the 5th BUS cycle
    core_write_i = 1'b1; core_addr_i = 32'h200; core_wdata_i = 32'hCAFE_F00D;
    tick();
    core_addr_i = 32'hFFFF_FFFF; core_wdata_i = 32'h0;  // holding regs must not follow
    for (int i = 0; i < 5; i++) begin
      chk("ws_cyc",  {63'd0, wb_cyc_o}, 64'd1);
      chk("ws_we",   {63'd0, wb_we_o}, 64'd1);
      chk("ws_addr", {32'd0, wb_addr_o}, 64'h200);
      chk("ws_data", {32'd0, wb_data_o}, 64'hCAFE_F00D);
      chk("ws_noresp", {63'd0, core_response_o}, 64'd0);
      if (i == 4) begin wb_ack_i = 1'b1; wb_data_i = 32'h5555_5555; end
      tick();
    end
    chk("ws_resp",  {63'd0, core_response_o}, 64'd1);
    chk("ws_rdata", {32'd0, core_rdata_o}, 64'h1234_5678);
    idle_inputs();
    tick();
    chk("ws_resp_one", {63'd0, core_response_o}, 64'd0);
    tick();

    // Timeout on read at 0x300
    core_read_i = 1'b1; core_addr_i = 32'h300;
    tick();
    n = 0;
    while (wb_cyc_o && n < 20) begin n++; tick(); end
    chk("to_len",   n, 64'd8);
    chk("to_resp",  {63'd0, core_response_o}, 64'd1);
    chk("to_rdata", {32'd0, core_rdata_o}, 64'hDEAD_BEEF);
    chk("to_flag",  {63'd0, timeout_o}, 64'd1);
    chk("to_eaddr", {32'd0, err_addr_o}, 64'h300);
    idle_inputs();
    tick(); tick();

    // Second timeout keeps the first address
    core_read_i = 1'b1; core_addr_i = 32'h400;
    tick();
    n = 0;
    while (wb_cyc_o && n < 20) begin n++; tick(); end
    chk("to2_len",   n, 64'd8);
    chk("to2_flag",  {63'd0, timeout_o}, 64'd1);
    chk("to2_eaddr", {32'd0, err_addr_o}, 64'h300);
    idle_inputs();
    tick(); tick();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk("clr_flag",  {63'd0, timeout_o}, 64'd0);
    chk("clr_eaddr", {32'd0, err_addr_o}, 64'd0);

    // Ack in the expiry cycle: ack wins
    core_read_i = 1'b1; core_addr_i = 32'h500;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin wb_ack_i = 1'b1; wb_data_i = 32'hA5A5_0001; end
      tick();
    end
    chk("edge_resp",  {63'd0, core_response_o}, 64'd1);
    chk("edge_rdata", {32'd0, core_rdata_o}, 64'hA5A5_0001);
    chk("edge_flag",  {63'd0, timeout_o}, 64'd0);
    idle_inputs();
    tick(); tick();

    // Read and write together: write wins
    core_read_i = 1'b1; core_write_i = 1'b1; core_addr_i = 32'h600; core_wdata_i = 32'h0BAD_CAFE;
    tick();
    chk("rw_we", {63'd0, wb_we_o}, 64'd1);
    wb_ack_i = 1'b1; wb_data_i = 32'h7777_7777;
    tick();
    chk("rw_rdata_hold", {32'd0, core_rdata_o}, 64'hA5A5_0001);
    idle_inputs();
    tick(); tick();

    // Stray ack in IDLE
    wb_ack_i = 1'b1; wb_data_i = 32'hFFFF_0000;
    tick();
    chk("stray_resp",  {63'd0, core_response_o}, 64'd0);
    chk("stray_cyc",   {63'd0, wb_cyc_o}, 64'd0);
    tick();
    chk("stray_rdata", {32'd0, core_rdata_o}, 64'hA5A5_0001);
    idle_inputs();
    tick();

    // Back-to-back: request and ack held for 12 cycles
    core_read_i = 1'b1; core_addr_i = 32'h700; wb_ack_i = 1'b1; wb_data_i = 32'h0000_0700;
    pulses = 0; cycs = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      pulses += int'(core_response_o);
      cycs   += int'(wb_cyc_o);
    end
    chk("b2b_pulses", pulses, 64'd4);
    chk("b2b_cycs",   cycs, 64'd4);
    idle_inputs();
    tick(); tick(); tick();

    // Reset in mid-BUS
    core_read_i = 1'b1; core_addr_i = 32'h800;
    tick();
    chk("mr_cyc_pre", {63'd0, wb_cyc_o}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_cyc",  {63'd0, wb_cyc_o}, 64'd0);
    chk("mr_stb",  {63'd0, wb_stb_o}, 64'd0);
    chk("mr_resp", {63'd0, core_response_o}, 64'd0);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_idle_cyc",  {63'd0, wb_cyc_o}, 64'd0);
    chk("mr_idle_resp", {63'd0, core_response_o}, 64'd0);
    // Fresh access after reset starts from IDLE with 2-cycle latency
    core_read_i = 1'b1; core_addr_i = 32'h900;
    tick();
    chk("mr_new_cyc", {63'd0, wb_cyc_o}, 64'd1);
    wb_ack_i = 1'b1; wb_data_i = 32'h0000_0900;
    tick();
    chk("mr_new_resp",  {63'd0, core_response_o}, 64'd1);
    chk("mr_new_rdata", {32'd0, core_rdata_o}, 64'h900);
    idle_inputs();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1);
  end

endmodule
